mem_access_unit: RTL and testbench

Memory-stage data-memory access unit, between EX_MEM and MEM_WB. Turns a load/store from EX_MEM into a word-aligned request on the data-memory port. Stalls the front of the pipeline until the access completes, then returns a byte-aligned, sign- or zero-extended load result straight to writeback. Keeps a one-entry last-store buffer that drives store-to-load forwarding (`store_load_hazard`, `store_data`) into MEM_WB.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/store_fwd_buffer.sv | 49 ++++
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: memory instruction IDs, memory-stage FSM states and
// the load lane-extract / extension helpers used by the access unit and its store buffer.
package core_pkg;

    localparam logic [5:0] ID_LB  = 6'h10;
    localparam logic [5:0] ID_LH  = 6'h11;
    localparam logic [5:0] ID_LW  = 6'h12;
    localparam logic [5:0] ID_LBU = 6'h13;
    localparam logic [5:0] ID_LHU = 6'h14;
    localparam logic [5:0] ID_SB  = 6'h18;
    localparam logic [5:0] ID_SH  = 6'h19;
    localparam logic [5:0] ID_SW  = 6'h1A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  addr_lo,
                                                input mem_size_t   size,
                                                input logic        is_signed);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] shifted;
        shifted = word >> {addr_lo, 3'b000};
        b = shifted[7:0];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_extend = {{24{is_signed & b[7]}}, b};
            SZ_HALF: load_extend = {{16{is_signed & h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    function automatic logic [3:0] byte_mask(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: byte_mask = 4'b0001 << addr_lo;
            SZ_HALF: byte_mask = 4'b0011 << addr_lo;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/store_fwd_buffer.sv
// One-entry last-store buffer: holds the most recent completed store and
// forwards an extended value to a load whose bytes it fully covers.
module store_fwd_buffer
    import core_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic [3:0]        lookup_mask,
    input  logic [1:0]        lookup_lo,
    input  mem_size_t         lookup_size,
    input  logic              lookup_sign,
    output logic              hit,
    output logic [31:0]       fwd_data
);

    logic              buf_vld;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_data;
    logic [3:0]        buf_strb;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld <= 1'b0;
        end else if (wr_en) begin
            buf_vld <= 1'b1;
        end
    end

    // Payload carries no reset: it is only ever consumed behind buf_vld.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_addr <= wr_addr;
            buf_data <= wr_data;
            buf_strb <= wr_strb;
        end
    end

    // Store data is lane-replicated, so the load's own lane reads the stored bytes.
    assign hit      = buf_vld && (buf_addr == lookup_addr) && ((lookup_mask & ~buf_strb) == 4'b0000);
    assign fwd_data = load_extend(buf_data, lookup_lo, lookup_size, lookup_sign);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues word-aligned data-memory requests, stalls the
// front of the pipeline while busy, and forwards fully covered loads from the last store.
module mem_access_unit
    import core_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid_in,
    input  logic [5:0]        instr_id_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [31:0]       store_value_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_wstrb,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_out,
    output logic              load_valid_out,
    output logic [31:0]       load_data_out,
    output logic              misaligned_out,
    output logic              store_load_hazard,
    output logic [31:0]       store_data
);

    mem_state_t state, state_next;

    logic              is_load, is_store, is_sign, mis, go, fwd_take, fwd_hit;
    mem_size_t         size;
    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        mask;
    logic [31:0]       wdata_new, fwd_data;

    logic              req_we, req_sign, req_is_load, fwd_flag;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_wstrb;
    logic [31:0]       req_wdata, result;
    logic [1:0]        req_lo;
    mem_size_t         req_size;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_sign  = 1'b0;
        size     = SZ_WORD;
        case (instr_id_in)
            ID_LB:  begin is_load = 1'b1;  size = SZ_BYTE; is_sign = 1'b1; end
            ID_LH:  begin is_load = 1'b1;  size = SZ_HALF; is_sign = 1'b1; end
            ID_LW:  begin is_load = 1'b1;  size = SZ_WORD; end
            ID_LBU: begin is_load = 1'b1;  size = SZ_BYTE; end
            ID_LHU: begin is_load = 1'b1;  size = SZ_HALF; end
            ID_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
            ID_SH:  begin is_store = 1'b1; size = SZ_HALF; end
            ID_SW:  begin is_store = 1'b1; size = SZ_WORD; end
            default: ;
        endcase
    end

    assign mis       = (is_load || is_store) &&
                       (((size == SZ_HALF) && mem_addr_in[0]) ||
                        ((size == SZ_WORD) && (mem_addr_in[1:0] != 2'b00)));
    assign go        = op_valid_in && (is_load || is_store) && !mis;
    assign word_addr = {mem_addr_in[ADDR_W-1:2], 2'b00};
    assign mask      = byte_mask(size, mem_addr_in[1:0]);
    assign fwd_take  = go && is_load && fwd_hit;

    always_comb begin
        case (size)
            SZ_BYTE: wdata_new = {4{store_value_in[7:0]}};
            SZ_HALF: wdata_new = {2{store_value_in[15:0]}};
            default: wdata_new = store_value_in;
        endcase
    end

    store_fwd_buffer #(.ADDR_W(ADDR_W)) u_store_fwd_buffer (
        .clk         (clk),
        .rst         (rst),
        .wr_en       ((state == ST_BUSY) && dmem_ready && req_we),
        .wr_addr     (req_addr),
        .wr_data     (req_wdata),
        .wr_strb     (req_wstrb),
        .lookup_addr (word_addr),
        .lookup_mask (mask),
        .lookup_lo   (mem_addr_in[1:0]),
        .lookup_size (size),
        .lookup_sign (is_sign),
        .hit         (fwd_hit),
        .fwd_data    (fwd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // DONE always returns to IDLE so a still-held EX_MEM op cannot retrigger.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (go) state_next = fwd_take ? ST_DONE : ST_BUSY;
            ST_BUSY: if (dmem_ready) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_we      <= 1'b0;
            req_sign    <= 1'b0;
            req_is_load <= 1'b0;
            fwd_flag    <= 1'b0;
            req_addr    <= '0;
            req_wstrb   <= 4'b0000;
            req_wdata   <= 32'h0;
            req_lo      <= 2'b00;
            req_size    <= SZ_WORD;
            result      <= 32'h0;
        end else if (state == ST_IDLE) begin
            if (go) begin
                req_we      <= is_store;
                req_sign    <= is_sign;
                req_is_load <= is_load;
                fwd_flag    <= fwd_take;
                req_addr    <= word_addr;
                req_wstrb   <= is_store ? mask : 4'b0000;
                req_wdata   <= is_store ? wdata_new : 32'h0;
                req_lo      <= mem_addr_in[1:0];
                req_size    <= size;
                if (fwd_take) result <= fwd_data;
            end
        end else if (state == ST_BUSY) begin
            if (dmem_ready && req_is_load)
                result <= load_extend(dmem_rdata, req_lo, req_size, req_sign);
        end
    end

    assign dmem_req          = (state == ST_BUSY);
    assign dmem_we           = dmem_req && req_we;
    assign dmem_wstrb        = dmem_req ? req_wstrb : 4'b0000;
    assign dmem_addr         = req_addr;
    assign dmem_wdata        = req_wdata;
    assign stall_out         = ((state == ST_IDLE) && go) || (state == ST_BUSY);
    assign misaligned_out    = (state == ST_IDLE) && op_valid_in && mis;
    assign load_valid_out    = (state == ST_DONE) && req_is_load;
    assign load_data_out     = result;
    assign store_load_hazard = (state == ST_DONE) && fwd_flag;
    assign store_data        = store_load_hazard ? result : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads with sign/zero extension,
// store-to-load forwarding, partial coverage, misalignment and reset during BUSY.
module tb_mem_access_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_in;
    logic [5:0]  instr_id_in;
    logic [31:0] mem_addr_in;
    logic [31:0] store_value_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall_out, load_valid_out, misaligned_out, store_load_hazard;
    logic [31:0] load_data_out, store_data;

    int errors = 0;
    int checks = 0;

    // Observations from the latest run_op call.
    int          o_stall, o_vld;
    logic        o_req, o_we, o_hz, o_mis;
    logic [31:0] o_addr, o_wdata, o_ldata, o_sdata;
    logic [3:0]  o_wstrb;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .op_valid_in(op_valid_in), .instr_id_in(instr_id_in),
        .mem_addr_in(mem_addr_in), .store_value_in(store_value_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall_out(stall_out), .load_valid_out(load_valid_out),
        .load_data_out(load_data_out), .misaligned_out(misaligned_out),
        .store_load_hazard(store_load_hazard), .store_data(store_data)
    );

    // Presents one op until the unit drops stall; memory answers on the delay-th BUSY cycle.
    task automatic run_op(input logic [5:0] id, input logic [31:0] addr, input logic [31:0] sval,
                          input int delay, input logic [31:0] rdata);
        int   busy;
        logic fin;
        busy = 0; fin = 1'b0;
        o_stall = 0; o_vld = 0; o_req = 0; o_we = 0; o_hz = 0; o_mis = 0;
        o_addr = 0; o_wdata = 0; o_wstrb = 0; o_ldata = 0; o_sdata = 0;
        op_valid_in = 1'b1; instr_id_in = id; mem_addr_in = addr; store_value_in = sval;
        dmem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (stall_out) o_stall++;
            if (misaligned_out) o_mis = 1'b1;
            if (dmem_req) begin
                o_req = 1'b1; o_addr = dmem_addr; o_we = dmem_we;
                o_wstrb = dmem_wstrb; o_wdata = dmem_wdata;
                busy++;
                if (busy == delay) begin dmem_ready = 1'b1; dmem_rdata = rdata; end
            end
            if (load_valid_out) begin o_vld++; o_ldata = load_data_out; end
            if (store_load_hazard) begin o_hz = 1'b1; o_sdata = store_data; end
            fin = !stall_out;
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            if (fin) break;
        end
        op_valid_in = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL op_timeout id=%h addr=%h: stall never released", id, addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid_in = 1'b0; instr_id_in = 6'h0; mem_addr_in = 0;
        store_value_in = 0; dmem_ready = 1'b0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({dmem_req, dmem_we, dmem_wstrb, load_valid_out, store_load_hazard, stall_out} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl got req=%b we=%b strb=%b lv=%b hz=%b stall=%b want all 0",
                     dmem_req, dmem_we, dmem_wstrb, load_valid_out, store_load_hazard, stall_out);
        end
        checks++;
        if ({dmem_addr, dmem_wdata, load_data_out, store_data} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h ld=%h sd=%h want 0",
                     dmem_addr, dmem_wdata, load_data_out, store_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        run_op(ID_SW, 32'h100, 32'hDEADBEEF, 1, 32'h0);
        checks++;
        if (!o_req || !o_we || o_addr !== 32'h100 || o_wstrb !== 4'b1111 || o_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_req got req=%b we=%b addr=%h strb=%b wdata=%h want 1 1 00000100 1111 deadbeef",
                     o_req, o_we, o_addr, o_wstrb, o_wdata);
        end
        checks++;
        if (o_stall != 2) begin errors++; $display("FAIL sw_stall got %0d want 2", o_stall); end
        checks++;
        if (o_vld != 0) begin errors++; $display("FAIL sw_no_load_valid got %0d want 0", o_vld); end
    endtask

    task automatic test_load_byte();
        run_op(ID_LB, 32'h202, 32'h0, 3, 32'h8899AABB);
        checks++;
        if (o_ldata !== 32'hFFFFFF99) begin errors++; $display("FAIL lb_data got %h want ffffff99", o_ldata); end
        checks++;
        if (o_vld != 1) begin errors++; $display("FAIL lb_valid_cycles got %0d want 1", o_vld); end
        checks++;
        if (o_stall != 4) begin errors++; $display("FAIL lb_stall got %0d want 4", o_stall); end
        checks++;
        if (o_addr !== 32'h200 || o_we !== 1'b0) begin
            errors++; $display("FAIL lb_req got addr=%h we=%b want 00000200 0", o_addr, o_we);
        end
        run_op(ID_LBU, 32'h202, 32'h0, 1, 32'h8899AABB);
        checks++;
        if (o_ldata !== 32'h00000099) begin errors++; $display("FAIL lbu_data got %h want 00000099", o_ldata); end
        run_op(ID_LH, 32'h202, 32'h0, 2, 32'h8899AABB);
        checks++;
        if (o_ldata !== 32'hFFFF8899) begin errors++; $display("FAIL lh_data got %h want ffff8899", o_ldata); end
    endtask

    task automatic test_forward();
        run_op(ID_SH, 32'h302, 32'h00001234, 2, 32'h0);
        checks++;
        if (o_wstrb !== 4'b1100 || o_wdata !== 32'h12341234 || o_addr !== 32'h300) begin
            errors++; $display("FAIL sh_req got strb=%b wdata=%h addr=%h want 1100 12341234 00000300",
                               o_wstrb, o_wdata, o_addr);
        end
        run_op(ID_LHU, 32'h302, 32'h0, 1, 32'hFFFFFFFF);
        checks++;
        if (o_req !== 1'b0) begin errors++; $display("FAIL fwd_no_req got req=%b want 0", o_req); end
        checks++;
        if (o_hz !== 1'b1 || o_sdata !== 32'h00001234) begin
            errors++; $display("FAIL fwd_hazard got hz=%b sd=%h want 1 00001234", o_hz, o_sdata);
        end
        checks++;
        if (o_stall != 1 || o_ldata !== 32'h00001234) begin
            errors++; $display("FAIL fwd_timing got stall=%0d ld=%h want 1 00001234", o_stall, o_ldata);
        end
    endtask

    task automatic test_partial();
        run_op(ID_SB, 32'h400, 32'h0000007F, 1, 32'h0);
        checks++;
        if (o_wstrb !== 4'b0001 || o_wdata !== 32'h7F7F7F7F) begin
            errors++; $display("FAIL sb_req got strb=%b wdata=%h want 0001 7f7f7f7f", o_wstrb, o_wdata);
        end
        run_op(ID_LW, 32'h400, 32'h0, 2, 32'hA5A5A57F);
        checks++;
        if (o_req !== 1'b1 || o_hz !== 1'b0) begin
            errors++; $display("FAIL partial_goes_to_mem got req=%b hz=%b want 1 0", o_req, o_hz);
        end
        checks++;
        if (o_ldata !== 32'hA5A5A57F) begin errors++; $display("FAIL partial_data got %h want a5a5a57f", o_ldata); end
    endtask

    task automatic test_misaligned();
        run_op(ID_LW, 32'h103, 32'h0, 1, 32'h0);
        checks++;
        if (o_mis !== 1'b1 || o_req !== 1'b0 || o_stall != 0) begin
            errors++; $display("FAIL misaligned got mis=%b req=%b stall=%0d want 1 0 0", o_mis, o_req, o_stall);
        end
    endtask

    task automatic test_reset_busy();
        run_op(ID_SW, 32'h500, 32'hCAFEF00D, 1, 32'h0);
        op_valid_in = 1'b1; instr_id_in = ID_SW; mem_addr_in = 32'h600; store_value_in = 32'h55AA55AA;
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b1) begin errors++; $display("FAIL busy_entry got req=%b want 1", dmem_req); end
        rst = 1'b1; op_valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_wstrb, stall_out, load_valid_out, store_load_hazard} !== 9'b0 ||
            {dmem_addr, dmem_wdata, load_data_out, store_data} !== 128'h0) begin
            errors++;
            $display("FAIL busy_reset got req=%b we=%b strb=%b stall=%b addr=%h wdata=%h ld=%h want all 0",
                     dmem_req, dmem_we, dmem_wstrb, stall_out, dmem_addr, dmem_wdata, load_data_out);
        end
        @(posedge clk); #1;
        run_op(ID_LW, 32'h500, 32'h0, 1, 32'h11223344);
        checks++;
        if (o_req !== 1'b1 || o_hz !== 1'b0 || o_ldata !== 32'h11223344) begin
            errors++; $display("FAIL buffer_cleared got req=%b hz=%b ld=%h want 1 0 11223344", o_req, o_hz, o_ldata);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_forward();
        test_partial();
        test_misaligned();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
